// File: rtl/event_index_encoder_pkg.sv
// Shared types and helpers for the event index encoder and its decode-side reference models.
package event_index_encoder_pkg;

  localparam int MAX_N     = 64;
  localparam int MAX_IDX_W = 6;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } enc_state_e;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } lsb_res_t;

  // Lowest set bit of a vector zero-extended to MAX_N; found=0 when vec is all zero.
  function automatic lsb_res_t lsb_index(input logic [MAX_N-1:0] vec);
    lsb_res_t r;
    r.found = 1'b0;
    r.idx   = '0;
    for (int k = MAX_N - 1; k >= 0; k--) begin
      if (vec[k]) begin
        r.found = 1'b1;
        r.idx   = MAX_IDX_W'(k);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/event_index_encoder_dec.sv
// Binary index to one-hot decoder with enable; out-of-range indices decode to zero.
module idx_dec #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [IDX_W-1:0] idx_i,
  input  logic             en_i,
  output logic [N-1:0]     onehot_o
);

  for (genvar k = 0; k < N; k++) begin : g_line
    assign onehot_o[k] = en_i && (idx_i == IDX_W'(k));
  end

endmodule

// File: rtl/event_index_encoder_prio_enc_lsb.sv
// Combinational lowest-set-bit priority encoder.
module prio_enc_lsb #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Scan high-to-low so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    any_o = |vec_i;
    for (int k = N - 1; k >= 0; k--) begin
      if (vec_i[k]) idx_o = IDX_W'(k);
    end
  end

endmodule

// File: rtl/event_index_encoder.sv
// Serialises multi-hot request events into a valid/ready stream of indices, lowest first.
module event_index_encoder
  import event_index_encoder_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [$clog2(N)-1:0] out_idx_o,
  output logic [N-1:0]         out_onehot_o,
  output logic                 dup_o,
  output logic                 busy_o
);

  localparam int IDX_W = $clog2(N);

  enc_state_e       state_q, state_n;
  logic [N-1:0]     pend_q, pend_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic             dup_q;

  logic [N-1:0]     cand;
  logic [IDX_W-1:0] lo_idx;
  logic             lo_any;
  logic [N-1:0]     lo_mask;

  assign cand    = pend_q | req_i;
  assign lo_mask = N'(1) << lo_idx;

  prio_enc_lsb #(.N(N), .IDX_W(IDX_W)) u_enc (
    .vec_i (cand),
    .idx_o (lo_idx),
    .any_o (lo_any)
  );

  // Whenever the output slot frees up, the lowest candidate moves into it in the same edge.
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    pend_n  = cand;
    unique case (state_q)
      EMPTY: begin
        if (lo_any) begin
          state_n = HOLD;
          idx_n   = lo_idx;
          pend_n  = cand & ~lo_mask;
        end
      end
      HOLD: begin
        if (out_ready_i) begin
          if (lo_any) begin
            idx_n  = lo_idx;
            pend_n = cand & ~lo_mask;
          end else begin
            state_n = EMPTY;
          end
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      pend_q  <= '0;
      idx_q   <= '0;
      dup_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      pend_q  <= pend_n;
      idx_q   <= idx_n;
      dup_q   <= |(req_i & pend_q);
    end
  end

  assign out_valid_o = (state_q == HOLD);
  assign out_idx_o   = idx_q;
  assign dup_o       = dup_q;
  assign busy_o      = (|pend_q) | out_valid_o;

  idx_dec #(.N(N), .IDX_W(IDX_W)) u_dec (
    .idx_i    (idx_q),
    .en_i     (out_valid_o),
    .onehot_o (out_onehot_o)
  );

endmodule
